ysyx_22041461_shift_pipe: RTL

Pipelined, parametrised shift unit for the NPC execute stage. It replaces the single-cycle combinational shifter with a `STAGES`-deep logarithmic barrel shifter behind valid/ready handshakes, so shift latency can be traded against clock frequency. It supports RV64 full-width and word (`*W`) shifts, with optional rotates, and sustains one result per cycle.

---
 rtl/ysyx_22041461_shift_pipe.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22041461_shift_pipe.sv
// Pipelined logarithmic barrel shifter for the execute stage: full-width and word shifts behind valid/ready.
// Optional rotates (ROL/ROR) are built only when YSYX_22041461_SHIFT_ROT_EN is defined.
module ysyx_22041461_shift_pipe #(
   parameter int unsigned XLEN   = 64,
   parameter int unsigned STAGES = 2,
   parameter int unsigned TAG_W  = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [XLEN-1:0]  in_src1,
   input  logic [XLEN-1:0]  in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int unsigned AMT_W       = $clog2(XLEN);
   localparam int unsigned LVL_PER_STG = (AMT_W + STAGES - 1) / STAGES;

   localparam logic [2:0] OP_SRLW = 3'b101;
   localparam logic [2:0] OP_SRAW = 3'b110;

   typedef struct packed {
      logic [XLEN-1:0]  data;
      logic [2:0]       op;
      logic [AMT_W-1:0] amt;
      logic [TAG_W-1:0] tag;
   } stage_t;

   logic [STAGES-1:0] valid_q;
   stage_t            stage_q [STAGES];
   stage_t            src     [STAGES];
   stage_t            nxt     [STAGES];
   logic [STAGES-1:0] src_v;
   logic [STAGES-1:0] ready;
   logic              all_v;
   stage_t            pre;
   logic              unused_src2;

   function automatic logic is_word(input logic [2:0] op);
      return op[2] && (op[1:0] != 2'b11);
   endfunction

   function automatic logic is_undef(input logic [2:0] op);
      logic u;
`ifdef YSYX_22041461_SHIFT_ROT_EN
      u = 1'b0;
`else
      u = (op[1:0] == 2'b11);
`endif
      if ((XLEN != 64) && is_word(op)) u = 1'b1;
      return u;
   endfunction

   // Apply barrel levels [lo, hi); each level i moves by 2^i when amt[i] is set.
   function automatic logic [XLEN-1:0] shift_levels(
      input logic [XLEN-1:0]  d,
      input logic [2:0]       op,
      input logic [AMT_W-1:0] amt,
      input int unsigned      lo,
      input int unsigned      hi
   );
      logic [XLEN-1:0] r;
      logic [XLEN-1:0] fill;
      r = d;
      for (int unsigned i = 0; i < AMT_W; i++) begin
         if ((i >= lo) && (i < hi) && amt[i]) begin
            fill = ((op[1:0] == 2'b10) && r[XLEN-1]) ? ~({XLEN{1'b1}} >> (1 << i)) : '0;
            unique case (op[1:0])
               2'b00:        r = r << (1 << i);
               2'b01, 2'b10: r = (r >> (1 << i)) | fill;
               default: begin
`ifdef YSYX_22041461_SHIFT_ROT_EN
                  if (op[2]) r = (r >> (1 << i)) | (r << (XLEN - (1 << i)));
                  else       r = (r << (1 << i)) | (r >> (XLEN - (1 << i)));
`endif
               end
            endcase
         end
      end
      return r;
   endfunction

   // Word results are sign-extended from bit 31; undefined ops complete with zero.
   function automatic logic [XLEN-1:0] finish_result(input logic [XLEN-1:0] d, input logic [2:0] op);
      logic [XLEN-1:0] r;
      r = d;
      if (is_word(op)) r = XLEN'($signed(d[31:0]));
      if (is_undef(op)) r = '0;
      return r;
   endfunction

   assign unused_src2 = ^in_src2[XLEN-1:AMT_W];

   // Input conditioning: word operands and 5-bit word shift amounts.
   always_comb begin
      pre      = '0;
      pre.data = in_src1;
      pre.op   = in_op;
      pre.amt  = in_src2[AMT_W-1:0];
      pre.tag  = in_tag;
      if (is_word(in_op)) begin
         pre.amt = AMT_W'(in_src2[4:0]);
         if (in_op == OP_SRLW)      pre.data = XLEN'(in_src1[31:0]);
         else if (in_op == OP_SRAW) pre.data = XLEN'($signed(in_src1[31:0]));
      end
   end

   // A stage may load when it or any stage downstream has room, or the consumer drains.
   always_comb begin
      all_v = 1'b1;
      ready = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         all_v    = all_v & valid_q[k];
         ready[k] = out_ready | ~all_v;
      end
   end

   always_comb begin
      src[0]   = pre;
      src_v[0] = in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
         src[k]   = stage_q[k-1];
         src_v[k] = valid_q[k-1];
      end
      for (int unsigned k = 0; k < STAGES; k++) begin
         nxt[k]      = src[k];
         nxt[k].data = shift_levels(src[k].data, src[k].op, src[k].amt,
                                    k * LVL_PER_STG, (k + 1) * LVL_PER_STG);
         if (k == STAGES - 1) nxt[k].data = finish_result(nxt[k].data, src[k].op);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= '0;
         for (int unsigned k = 0; k < STAGES; k++) stage_q[k] <= '0;
      end else begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            if (flush)         valid_q[k] <= 1'b0;
            else if (ready[k]) valid_q[k] <= src_v[k];
            if (!flush && ready[k] && src_v[k]) stage_q[k] <= nxt[k];
         end
      end
   end

   assign in_ready   = ready[0];
   assign out_valid  = valid_q[STAGES-1];
   assign out_result = stage_q[STAGES-1].data;
   assign out_tag    = stage_q[STAGES-1].tag;

endmodule
